membus_initiator: RTL and testbench

//  Processor-side master for the PDP-6 memory bus: issues read, write and read-pause-write cycles to core or fast memory.

---
 rtl/membus_initiator_if.sv | 31 +++
 rtl/membus_initiator.sv | 193 +++++++++++++++++++
 tb/tb_membus_initiator.sv | 356 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/membus_initiator_if.sv
`default_nettype none
// ============================================================================
//  Module      : membus_initiator_if
//  Description : PDP-6 memory bus signal bundle between a processor-side
//                initiator (master) and a memory port (slave).
//  Revision    : 1.0  initial release
// ============================================================================
interface membus_initiator_if;
   logic        mc_rq_cyc;
   logic        mc_rd_rq;
   logic        mc_wr_rq;
   logic [14:0] ma;
   logic [3:0]  sel;
   logic        fmc_select;
   logic [35:0] mb_out;
   logic        mc_wr_rs;
   logic [35:0] mb_in;
   logic        cmc_addr_ack;
   logic        cmc_rd_rs;

   modport master (
      output mc_rq_cyc, mc_rd_rq, mc_wr_rq, ma, sel, fmc_select, mb_out, mc_wr_rs,
      input  mb_in, cmc_addr_ack, cmc_rd_rs
   );

   modport slave (
      input  mc_rq_cyc, mc_rd_rq, mc_wr_rq, ma, sel, fmc_select, mb_out, mc_wr_rs,
      output mb_in, cmc_addr_ack, cmc_rd_rs
   );
endinterface
`default_nettype wire

// File: rtl/membus_initiator.sv
`default_nettype none
// ============================================================================
//  Module      : membus_initiator
//  Description : Processor-side PDP-6 memory bus master. Runs read, write and
//                read-pause-write cycles; flags nonexistent memory when the
//                address acknowledge never arrives.
//  Revision    : 1.0  initial release
// ============================================================================
module membus_initiator #(
   parameter int ACK_TIMEOUT = 1000,
   parameter int RD_WINDOW   = 6,
   parameter int WR_SETUP    = 4,
   parameter int WR_HOLD     = 6
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      cpu_start,
   input  logic                      cpu_rd,
   input  logic                      cpu_wr,
   input  logic [17:0]               cpu_addr,
   input  logic                      cpu_fm_en,
   input  logic [35:0]               cpu_wdata,
   input  logic                      cpu_wr_go,
   output logic                      cpu_busy,
   output logic                      cpu_pause,
   output logic                      cpu_done,
   output logic                      cpu_nxm,
   output logic [35:0]               cpu_rdata,
   membus_initiator_if.master        bus
);

   // One shared timer serves every timed state; size it for the longest one.
   localparam int MAX_A   = (ACK_TIMEOUT > RD_WINDOW) ? ACK_TIMEOUT : RD_WINDOW;
   localparam int MAX_B   = (WR_SETUP > WR_HOLD) ? WR_SETUP : WR_HOLD;
   localparam int MAX_CNT = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int CW      = $clog2(MAX_CNT + 1);

   localparam logic [CW-1:0] ACK_LAST   = CW'(ACK_TIMEOUT - 1);
   localparam logic [CW-1:0] RD_LAST    = CW'(RD_WINDOW - 1);
   localparam logic [CW-1:0] SETUP_LAST = CW'(WR_SETUP - 1);
   localparam logic [CW-1:0] HOLD_LAST  = CW'(WR_HOLD - 1);

   localparam logic [3:0] S_IDLE   = 4'd0;
   localparam logic [3:0] S_RQ     = 4'd1;
   localparam logic [3:0] S_RWAIT  = 4'd2;
   localparam logic [3:0] S_RSTRB  = 4'd3;
   localparam logic [3:0] S_RDONE  = 4'd4;
   localparam logic [3:0] S_PAUSE  = 4'd5;
   localparam logic [3:0] S_WSETUP = 4'd6;
   localparam logic [3:0] S_WRS    = 4'd7;
   localparam logic [3:0] S_WHOLD  = 4'd8;

   logic [3:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          rd_q, rd_d;
   logic          wr_q, wr_d;
   logic [14:0]   ma_q, ma_d;
   logic [3:0]    sel_q, sel_d;
   logic          fmc_q, fmc_d;
   logic [35:0]   wdata_q, wdata_d;
   logic [35:0]   rdata_q, rdata_d;

   logic fm_hit;
   logic driving;

   // Low sixteen addresses go to fast memory only when it is enabled.
   assign fm_hit  = cpu_fm_en && (cpu_addr < 18'd16);
   assign driving = (state_q == S_WSETUP) || (state_q == S_WRS) || (state_q == S_WHOLD);

   // Next-state, latch and timer logic for the bus cycle sequencer.
   always_comb begin
      state_d = state_q;
      rd_d    = rd_q;
      wr_d    = wr_q;
      ma_d    = ma_q;
      sel_d   = sel_q;
      fmc_d   = fmc_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      cnt_d   = cnt_q;

      case (state_q)
         S_IDLE: begin
            if (cpu_start && (cpu_rd || cpu_wr)) begin
               state_d = S_RQ;
               rd_d    = cpu_rd;
               wr_d    = cpu_wr;
               ma_d    = cpu_addr[14:0];
               sel_d   = {cpu_addr[17:15], fm_hit};
               fmc_d   = fm_hit;
               rdata_d = '0;
            end
         end
         S_RQ: begin
            if (bus.cmc_addr_ack) begin
               if (!rd_q)
                  state_d = S_WSETUP;
               else if (bus.cmc_rd_rs)
                  state_d = S_RSTRB;   // restart arrived together with the ack
               else
                  state_d = S_RWAIT;
            end else if (cnt_q == ACK_LAST) begin
               state_d = S_IDLE;       // nonexistent memory
            end
         end
         S_RWAIT: begin
            if (bus.cmc_rd_rs)
               state_d = S_RSTRB;
         end
         S_RSTRB: begin
            rdata_d = rdata_q | bus.mb_in;
            if (cnt_q == RD_LAST)
               state_d = S_RDONE;
         end
         S_RDONE: begin
            state_d = wr_q ? S_PAUSE : S_IDLE;
         end
         S_PAUSE: begin
            if (cpu_wr_go)
               state_d = S_WSETUP;
         end
         S_WSETUP: begin
            if (cnt_q == SETUP_LAST)
               state_d = S_WRS;
         end
         S_WRS: begin
            state_d = S_WHOLD;
         end
         S_WHOLD: begin
            if (cnt_q == HOLD_LAST)
               state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Write data is captured once, on the way into the setup phase.
      if ((state_d == S_WSETUP) && (state_q != S_WSETUP))
         wdata_d = cpu_wdata;

      // Timer restarts on every state change and saturates otherwise.
      if (state_d != state_q)
         cnt_d = '0;
      else if (cnt_q != '1)
         cnt_d = cnt_q + 1'b1;
   end

   // State and latch registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
         ma_q    <= '0;
         sel_q   <= '0;
         fmc_q   <= 1'b0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         ma_q    <= ma_d;
         sel_q   <= sel_d;
         fmc_q   <= fmc_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
      end
   end

   // Processor-side status decoded from the state register.
   assign cpu_busy  = (state_q != S_IDLE);
   assign cpu_pause = (state_q == S_PAUSE);
   assign cpu_done  = ((state_q == S_RDONE) && !wr_q) ||
                      ((state_q == S_WHOLD) && (cnt_q == HOLD_LAST));
   assign cpu_nxm   = (state_q == S_RQ) && !bus.cmc_addr_ack && (cnt_q == ACK_LAST);
   assign cpu_rdata = rdata_q;

   // Bus lines are gated by state so that leaving a cycle drops them all.
   assign bus.mc_rq_cyc  = (state_q == S_RQ);
   assign bus.mc_rd_rq   = cpu_busy && rd_q;
   assign bus.mc_wr_rq   = cpu_busy && wr_q;
   assign bus.ma         = cpu_busy ? ma_q : '0;
   assign bus.sel        = cpu_busy ? sel_q : '0;
   assign bus.fmc_select = cpu_busy && fmc_q;
   assign bus.mb_out     = driving ? wdata_q : '0;
   assign bus.mc_wr_rs   = (state_q == S_WRS);

endmodule
`default_nettype wire

// File: tb/tb_membus_initiator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_membus_initiator
//  Description : Directed self-checking bench for membus_initiator.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_membus_initiator;
   logic        clk = 1'b0;
   logic        reset;
   logic        cpu_start, cpu_rd, cpu_wr, cpu_fm_en, cpu_wr_go;
   logic [17:0] cpu_addr;
   logic [35:0] cpu_wdata;
   logic        cpu_busy, cpu_pause, cpu_done, cpu_nxm;
   logic [35:0] cpu_rdata;

   int pass_cnt  = 0;
   int total_cnt = 0;
   int done_cnt  = 0;
   int nxm_cnt   = 0;

   membus_initiator_if bus();

   membus_initiator #(
      .ACK_TIMEOUT(1000),
      .RD_WINDOW  (6),
      .WR_SETUP   (4),
      .WR_HOLD    (6)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .cpu_start(cpu_start),
      .cpu_rd   (cpu_rd),
      .cpu_wr   (cpu_wr),
      .cpu_addr (cpu_addr),
      .cpu_fm_en(cpu_fm_en),
      .cpu_wdata(cpu_wdata),
      .cpu_wr_go(cpu_wr_go),
      .cpu_busy (cpu_busy),
      .cpu_pause(cpu_pause),
      .cpu_done (cpu_done),
      .cpu_nxm  (cpu_nxm),
      .cpu_rdata(cpu_rdata),
      .bus      (bus)
   );

   always #5 clk = ~clk;

   wire [99:0] all_out = {cpu_busy, cpu_pause, cpu_done, cpu_nxm, cpu_rdata,
                          bus.mc_rq_cyc, bus.mc_rd_rq, bus.mc_wr_rq, bus.ma, bus.sel,
                          bus.fmc_select, bus.mb_out, bus.mc_wr_rs};

   // Pulse counters, sampled mid-cycle.
   always @(negedge clk) begin
      #2;
      if (cpu_done === 1'b1) done_cnt++;
      if (cpu_nxm === 1'b1) nxm_cnt++;
   end

   task automatic cyc();
      @(negedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      cpu_start = 0; cpu_rd = 0; cpu_wr = 0; cpu_addr = '0; cpu_fm_en = 0;
      cpu_wdata = '0; cpu_wr_go = 0;
      bus.mb_in = '0; bus.cmc_addr_ack = 0; bus.cmc_rd_rs = 0;
   endtask

   // Pulse cpu_start; returns during the first RQ cycle.
   task automatic start(input logic rd, input logic wr, input logic [17:0] a,
                        input logic fm, input logic [35:0] wd);
      cpu_start = 1; cpu_rd = rd; cpu_wr = wr; cpu_addr = a; cpu_fm_en = fm; cpu_wdata = wd;
      cyc();
      cpu_start = 0;
   endtask

   task automatic test_reset();
      reset = 1;
      idle_inputs();
      cyc();
      cyc();
      total_cnt++;
      if (all_out !== '0) $display("FAIL reset_outputs: got %h expected 0", all_out);
      else pass_cnt++;
      reset = 0;
      cyc();
   endtask

   task automatic test_read_ok();
      int d0;
      d0 = done_cnt;
      start(1, 0, 18'o1234, 0, '0);
      total_cnt++;
      if ({cpu_busy, bus.mc_rq_cyc, bus.mc_rd_rq, bus.mc_wr_rq} !== 4'b1110)
         $display("FAIL read_rq_lines: got %b expected 1110",
                  {cpu_busy, bus.mc_rq_cyc, bus.mc_rd_rq, bus.mc_wr_rq});
      else pass_cnt++;
      total_cnt++;
      if ({bus.ma, bus.sel} !== {15'o1234, 4'd0})
         $display("FAIL read_ma_sel: got ma=%o sel=%b expected ma=1234 sel=0000", bus.ma, bus.sel);
      else pass_cnt++;
      cyc(); cyc();
      bus.cmc_addr_ack = 1;
      cyc();
      bus.cmc_addr_ack = 0;
      total_cnt++;
      if ({bus.mc_rq_cyc, bus.mc_rd_rq, cpu_busy} !== 3'b011)
         $display("FAIL read_after_ack: got %b expected 011", {bus.mc_rq_cyc, bus.mc_rd_rq, cpu_busy});
      else pass_cnt++;
      cyc();
      bus.cmc_rd_rs = 1;
      cyc();
      bus.cmc_rd_rs = 0; bus.mb_in = 36'o123456701234;
      cyc();
      cyc();
      bus.mb_in = '0;
      repeat (3) cyc();
      cyc();
      total_cnt++;
      if ({cpu_done, cpu_rdata} !== {1'b1, 36'o123456701234})
         $display("FAIL read_done_data: got done=%b rdata=%o expected done=1 rdata=123456701234",
                  cpu_done, cpu_rdata);
      else pass_cnt++;
      cyc();
      total_cnt++;
      if ({cpu_busy, bus.mc_rd_rq, cpu_rdata, done_cnt - d0} !== {1'b0, 1'b0, 36'o123456701234, 32'd1})
         $display("FAIL read_idle: got busy=%b rd_rq=%b rdata=%o dones=%0d expected 0 0 123456701234 1",
                  cpu_busy, bus.mc_rd_rq, cpu_rdata, done_cnt - d0);
      else pass_cnt++;
   endtask

   task automatic test_fm_write();
      int d0;
      d0 = done_cnt;
      start(0, 1, 18'd5, 1, 36'o777000777000);
      total_cnt++;
      if ({bus.fmc_select, bus.mc_wr_rq, bus.mc_rd_rq, bus.mb_out} !== {3'b110, 36'd0})
         $display("FAIL fmw_rq_lines: got fmc=%b wr_rq=%b rd_rq=%b mb_out=%o expected 1 1 0 0",
                  bus.fmc_select, bus.mc_wr_rq, bus.mc_rd_rq, bus.mb_out);
      else pass_cnt++;
      bus.cmc_addr_ack = 1;
      for (int i = 1; i <= 11; i++) begin
         cyc();
         total_cnt++;
         if ({bus.mb_out, bus.mc_wr_rs, cpu_done} !== {36'o777000777000, (i == 5), (i == 11)})
            $display("FAIL fmw_phase_%0d: got mb_out=%o wr_rs=%b done=%b expected 777000777000 %b %b",
                     i, bus.mb_out, bus.mc_wr_rs, cpu_done, (i == 5), (i == 11));
         else pass_cnt++;
         if (i == 1) begin
            bus.cmc_addr_ack = 0;
            cpu_wdata = 36'o111111111111;
         end
      end
      cyc();
      total_cnt++;
      if ({bus.mb_out, bus.mc_wr_rq, bus.fmc_select, cpu_busy, done_cnt - d0} !== {36'd0, 3'b000, 32'd1})
         $display("FAIL fmw_idle: got mb_out=%o wr_rq=%b fmc=%b busy=%b dones=%0d expected 0 0 0 0 1",
                  bus.mb_out, bus.mc_wr_rq, bus.fmc_select, cpu_busy, done_cnt - d0);
      else pass_cnt++;
   endtask

   task automatic test_rmw();
      int d0;
      d0 = done_cnt;
      start(1, 1, 18'o100, 0, 36'o5);
      bus.cmc_addr_ack = 1;
      cyc();
      bus.cmc_addr_ack = 0; bus.cmc_rd_rs = 1;
      cyc();
      bus.cmc_rd_rs = 0; bus.mb_in = 36'o1;
      cyc();
      bus.mb_in = '0;
      repeat (4) cyc();
      cyc();
      total_cnt++;
      if ({cpu_done, cpu_pause, cpu_rdata} !== {2'b00, 36'o1})
         $display("FAIL rmw_rdone: got done=%b pause=%b rdata=%o expected 0 0 1", cpu_done, cpu_pause, cpu_rdata);
      else pass_cnt++;
      cyc();
      total_cnt++;
      if ({cpu_pause, bus.mc_rd_rq, bus.mc_wr_rq, cpu_busy} !== 4'b1111)
         $display("FAIL rmw_pause: got %b expected 1111", {cpu_pause, bus.mc_rd_rq, bus.mc_wr_rq, cpu_busy});
      else pass_cnt++;
      repeat (9) cyc();
      total_cnt++;
      if ({cpu_pause, bus.mb_out} !== {1'b1, 36'd0})
         $display("FAIL rmw_pause_hold: got pause=%b mb_out=%o expected 1 0", cpu_pause, bus.mb_out);
      else pass_cnt++;
      cpu_wdata = 36'o2;
      cpu_wr_go = 1;
      cyc();
      cpu_wr_go = 0;
      total_cnt++;
      if ({cpu_pause, bus.mc_rd_rq, bus.mc_wr_rq, bus.mb_out} !== {3'b011, 36'o2})
         $display("FAIL rmw_wsetup: got pause=%b rd_rq=%b wr_rq=%b mb_out=%o expected 0 1 1 2",
                  cpu_pause, bus.mc_rd_rq, bus.mc_wr_rq, bus.mb_out);
      else pass_cnt++;
      repeat (10) cyc();
      total_cnt++;
      if ({cpu_done, bus.mb_out} !== {1'b1, 36'o2})
         $display("FAIL rmw_done: got done=%b mb_out=%o expected 1 2", cpu_done, bus.mb_out);
      else pass_cnt++;
      cyc();
      total_cnt++;
      if ({cpu_busy, bus.mc_rd_rq, bus.mc_wr_rq, bus.mb_out, done_cnt - d0} !== {39'd0, 32'd1})
         $display("FAIL rmw_idle: got busy=%b rd_rq=%b wr_rq=%b mb_out=%o dones=%0d expected 0 0 0 0 1",
                  cpu_busy, bus.mc_rd_rq, bus.mc_wr_rq, bus.mb_out, done_cnt - d0);
      else pass_cnt++;
   endtask

   task automatic test_nxm();
      int d0;
      int n0;
      int first;
      d0 = done_cnt;
      n0 = nxm_cnt;
      first = 0;
      start(1, 0, 18'o200000, 0, '0);
      for (int i = 1; i <= 1010 && first == 0; i++) begin
         if (cpu_nxm === 1'b1) first = i;
         else cyc();
      end
      total_cnt++;
      if (first != 1000)
         $display("FAIL nxm_cycle: got nxm at RQ cycle %0d (0 = never) expected 1000", first);
      else pass_cnt++;
      cyc();
      total_cnt++;
      if ({cpu_busy, bus.mc_rq_cyc, bus.mc_rd_rq, nxm_cnt - n0, done_cnt - d0} !== {3'b000, 32'd1, 32'd0})
         $display("FAIL nxm_after: got busy=%b rq_cyc=%b rd_rq=%b nxms=%0d dones=%0d expected 0 0 0 1 0",
                  cpu_busy, bus.mc_rq_cyc, bus.mc_rd_rq, nxm_cnt - n0, done_cnt - d0);
      else pass_cnt++;
   endtask

   task automatic test_reset_midcycle();
      start(1, 1, 18'o100, 0, 36'o5);
      bus.cmc_addr_ack = 1;
      cyc();
      bus.cmc_addr_ack = 0; bus.cmc_rd_rs = 1;
      cyc();
      bus.cmc_rd_rs = 0; bus.mb_in = 36'o7;
      cyc();
      bus.mb_in = '0;
      repeat (6) cyc();
      total_cnt++;
      if (cpu_pause !== 1'b1) $display("FAIL rst_reach_pause: got pause=%b expected 1", cpu_pause);
      else pass_cnt++;
      reset = 1;
      cyc();
      reset = 0;
      total_cnt++;
      if (all_out !== '0) $display("FAIL rst_in_pause: got %h expected 0", all_out);
      else pass_cnt++;

      start(0, 1, 18'o3, 0, 36'o444444444444);
      bus.cmc_addr_ack = 1;
      cyc();
      bus.cmc_addr_ack = 0;
      repeat (5) cyc();
      total_cnt++;
      if ({bus.mb_out, bus.mc_wr_rs, cpu_busy} !== {36'o444444444444, 2'b01})
         $display("FAIL rst_reach_whold: got mb_out=%o wr_rs=%b busy=%b expected 444444444444 0 1",
                  bus.mb_out, bus.mc_wr_rs, cpu_busy);
      else pass_cnt++;
      reset = 1;
      cyc();
      reset = 0;
      total_cnt++;
      if (all_out !== '0) $display("FAIL rst_in_whold: got %h expected 0", all_out);
      else pass_cnt++;

      // Recovery read; ack and restart arrive together, data ORs over two beats.
      start(1, 0, 18'o612345, 0, '0);
      total_cnt++;
      if ({bus.ma, bus.sel} !== {15'o12345, 4'b1100})
         $display("FAIL rec_ma_sel: got ma=%o sel=%b expected 12345 1100", bus.ma, bus.sel);
      else pass_cnt++;
      bus.cmc_addr_ack = 1; bus.cmc_rd_rs = 1;
      cyc();
      bus.cmc_addr_ack = 0; bus.cmc_rd_rs = 0; bus.mb_in = 36'o700000000000;
      cyc();
      bus.mb_in = 36'o77;
      cyc();
      bus.mb_in = '0;
      repeat (4) cyc();
      total_cnt++;
      if ({cpu_done, cpu_rdata} !== {1'b1, 36'o700000000077})
         $display("FAIL rec_done_data: got done=%b rdata=%o expected 1 700000000077", cpu_done, cpu_rdata);
      else pass_cnt++;
      cyc();
      total_cnt++;
      if (cpu_busy !== 1'b0) $display("FAIL rec_idle: got busy=%b expected 0", cpu_busy);
      else pass_cnt++;
   endtask

   task automatic test_ignored();
      cpu_start = 1; cpu_rd = 0; cpu_wr = 0;
      bus.cmc_addr_ack = 1; bus.cmc_rd_rs = 1;
      cyc();
      cpu_start = 0; bus.cmc_addr_ack = 0; bus.cmc_rd_rs = 0;
      total_cnt++;
      if ({cpu_busy, bus.mc_rq_cyc, bus.mc_rd_rq, bus.mc_wr_rq} !== 4'b0000)
         $display("FAIL ign_idle: got %b expected 0000", {cpu_busy, bus.mc_rq_cyc, bus.mc_rd_rq, bus.mc_wr_rq});
      else pass_cnt++;
      start(1, 0, 18'o4321, 0, '0);
      cpu_start = 1; cpu_rd = 0; cpu_wr = 1; cpu_addr = 18'o7777;
      cyc();
      cpu_start = 0; cpu_wr = 0;
      total_cnt++;
      if ({bus.ma, bus.mc_wr_rq, bus.mc_rd_rq, bus.mc_rq_cyc} !== {15'o4321, 3'b011})
         $display("FAIL ign_start_busy: got ma=%o wr_rq=%b rd_rq=%b rq_cyc=%b expected 4321 0 1 1",
                  bus.ma, bus.mc_wr_rq, bus.mc_rd_rq, bus.mc_rq_cyc);
      else pass_cnt++;
      bus.cmc_addr_ack = 1;
      cyc();
      bus.cmc_addr_ack = 0; cpu_wr_go = 1;
      cyc();
      cpu_wr_go = 0;
      total_cnt++;
      if ({cpu_busy, cpu_pause, bus.mc_rq_cyc, bus.mc_rd_rq, bus.mb_out} !== {4'b1001, 36'd0})
         $display("FAIL ign_wr_go: got busy=%b pause=%b rq_cyc=%b rd_rq=%b mb_out=%o expected 1 0 0 1 0",
                  cpu_busy, cpu_pause, bus.mc_rq_cyc, bus.mc_rd_rq, bus.mb_out);
      else pass_cnt++;
      bus.cmc_rd_rs = 1;
      cyc();
      bus.cmc_rd_rs = 0; bus.mb_in = 36'o42;
      cyc();
      bus.mb_in = '0;
      repeat (5) cyc();
      total_cnt++;
      if ({cpu_done, cpu_rdata} !== {1'b1, 36'o42})
         $display("FAIL ign_read_done: got done=%b rdata=%o expected 1 42", cpu_done, cpu_rdata);
      else pass_cnt++;
      cyc();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got running expected finished");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_read_ok();
      test_fm_write();
      test_rmw();
      test_nxm();
      test_reset_midcycle();
      test_ignored();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
`default_nettype wire
